diff_word_decode: RTL and testbench
===================================

DIFF_WORD_DECODE -- requirements
Module: diff_word_decode

Interface
REQ-001 Parameter N, default 8, SHALL set the digits per word (2 bits per digit); legal range N >= 2.
REQ-002 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 in_valid  input  1  SHALL flag that in_word holds a differential word.
REQ-005 in_word  input  2N  SHALL carry the differential word; the MS digit is the absolute first digit, and each lower digit i is (orig[i] - orig[i+1]) mod 4.
REQ-006 in_ready  output  1  SHALL flag that the block can accept a word.
REQ-007 out_valid  output  1  SHALL flag that out_word holds a decoded word.
REQ-008 out_word  output  2N  SHALL carry the reconstructed original word, same digit order as in_word.
REQ-009 out_ready  input  1  SHALL flag that the consumer accepts out_word.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 word_count  output  16  SHALL count completed output handshakes.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, DECODE and OUTPUT.
REQ-013 In IDLE, in_ready SHALL be 1; in DECODE and OUTPUT, in_ready SHALL be 0.
REQ-014 An input handshake (in_valid & in_ready at an edge) SHALL:
- capture in_word into an internal register;
- copy the MS digit unchanged into result digit N-1;
- load the digit index with N-2;
- move the FSM to DECODE.
REQ-015 In DECODE, each edge SHALL compute exactly one digit: result[i] = (diff[i] + result[i+1]) mod 4, using the low 2 bits of a 3-bit sum, where i is the digit index.
REQ-016 In DECODE, the digit index SHALL decrement after each computed digit; the edge that computes digit 0 SHALL move the FSM to OUTPUT.
REQ-017 Latency SHALL be fixed: with acceptance at edge E0, out_valid SHALL rise after edge E(N-1), i.e. N-1 DECODE cycles, independent of data.
REQ-018 In OUTPUT, out_valid SHALL be 1, and out_word SHALL equal the full result and hold stable until an output handshake.
REQ-019 An output handshake (out_valid & out_ready at an edge) SHALL:
- return the FSM to IDLE;
- deassert out_valid in the next cycle;
- increment word_count by 1, wrapping from 0xFFFF to 0x0000.
REQ-020 Outside OUTPUT, out_valid SHALL be 0; out_word SHALL hold its last value and is don't-care for consumers.
REQ-021 A stalled consumer (out_ready=0) SHALL hold OUTPUT indefinitely; no input is accepted and no data is lost.
REQ-022 Because in_ready is 0 in OUTPUT, the block SHALL NOT accept a new word on the same edge as an output handshake; back-to-back throughput is one word per N+1 cycles.
REQ-023 in_valid and in_word SHALL be ignored in DECODE and OUTPUT; changes to them SHALL NOT affect the word in flight.
REQ-024 For every legal input, decode(encode(x)) SHALL equal x.

Reset
REQ-025 While rst is high, the block SHALL hold:
- FSM = IDLE;
- out_valid = 0, out_word = 0;
- word_count = 0, busy = 0;
- in_ready = 0.
REQ-026 After rst deasserts, in_ready SHALL become 1 combinationally from IDLE.
REQ-027 Reset asserted mid-DECODE or mid-OUTPUT SHALL immediately abort the word in flight; the aborted word SHALL NOT be output and SHALL NOT be counted.

Verification
REQ-028 N=8, in_word=0x153F, out_ready=1 -> out_word=0x1BE4, out_valid high 7 edges after the accept edge, word_count=1.
REQ-029 in_word=0xFFFF -> out_word=0xE4E4; in_word=0x0000 -> out_word=0x0000 (covers mod-4 wrap and zero).
REQ-030 Output stall: hold out_ready=0 for 20 cycles after out_valid rises -> out_word stays 0x1BE4, in_ready stays 0, and a toggling in_valid/in_word is ignored; on release, exactly one handshake occurs and word_count increments by 1.
REQ-031 Assert rst 3 cycles into DECODE -> out_valid=0, word_count unchanged at 0, in_ready=1 after release; the next word decodes correctly.
REQ-032 Random-word stream through an encoder model, with random in_valid/out_ready -> every out_word equals the original word, in order, and the word_count wrap at 65536 is checked by forcing a preloaded count.

Source files
------------

// File: rtl/diff_word_decode.sv
`default_nettype none
// ============================================================================
// Module  : diff_word_decode
// Brief   : Rebuilds a word of 2-bit digits from its differential form,
//           resolving one digit per clock from the MS digit downwards.
// Rev     : 1.0  initial release
// ============================================================================
module diff_word_decode #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [2*N-1:0] in_word,
  output logic           in_ready,
  output logic           out_valid,
  output logic [2*N-1:0] out_word,
  input  logic           out_ready,
  output logic           busy,
  output logic [15:0]    word_count
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*N-3:0]  r_diff;      // MS digit is copied straight into the result
  logic [2*N-1:0]  r_result;
  logic [2*N-1:0]  r_out;
  logic [IW-1:0]   r_idx;
  logic [15:0]     r_word_count;

  logic            w_accept;
  logic            w_out_hs;
  logic            w_last;
  logic [2:0]      w_sum;
  logic [1:0]      w_digit;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = (r_state == S_OUTPUT);
  assign busy       = (r_state != S_IDLE);
  assign out_word   = r_out;
  assign word_count = r_word_count;

  assign w_accept = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_last   = (r_state == S_DECODE) && (r_idx == '0);

  assign w_sum   = {1'b0, r_diff[2*int'(r_idx) +: 2]}
                 + {1'b0, r_result[2*int'(r_idx) + 2 +: 2]};
  assign w_digit = w_sum[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_DECODE;
      S_DECODE: if (r_idx == '0) w_state_nxt = S_OUTPUT;
      S_OUTPUT: if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff       <= '0;
      r_result     <= '0;
      r_out        <= '0;
      r_idx        <= '0;
      r_word_count <= '0;
    end else begin
      if (w_accept) begin
        r_diff   <= in_word[2*N-3:0];
        r_result <= {in_word[2*N-1 -: 2], {(2*N-2){1'b0}}};
        r_idx    <= IW'(N-2);
      end else if (r_state == S_DECODE) begin
        r_result[2*int'(r_idx) +: 2] <= w_digit;
        r_idx                        <= r_idx - 1'b1;
        // Publish only complete words so out_word never shows partial results
        if (w_last) begin
          r_out <= {r_result[2*N-1:2], w_digit};
        end
      end
      if (w_out_hs) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_diff_word_decode.sv
`default_nettype none
// ============================================================================
// Module  : tb_diff_word_decode
// Brief   : Scoreboard bench for diff_word_decode with an encoder model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_diff_word_decode;

  localparam int N = 8;
  localparam int W = 2 * N;

  typedef struct {
    logic [W-1:0] exp;
    int           acc;
  } item_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_word;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_word;
  logic         out_ready;
  logic         busy;
  logic [15:0]  word_count;

  item_t        q[$];
  int           n_tests;
  int           n_fail;
  int           cyc;
  int           mode;
  logic [15:0]  exp_count;
  logic         prev_ov;
  logic         hs_prev;

  diff_word_decode #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (out_ready),
    .busy      (busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Differential encoding: MS digit absolute, others are the mod-4 step from the digit above
  function automatic logic [W-1:0] encode(input logic [W-1:0] x);
    logic [W-1:0] d;
    d = x;
    for (int i = 0; i < N - 1; i++) begin
      d[2*i +: 2] = x[2*i +: 2] - x[2*i+2 +: 2];
    end
    return d;
  endfunction

  task automatic send(input logic [W-1:0] w, input logic [W-1:0] exp);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("send_accepted", in_ready, 1'b1);
    if (in_ready) q.push_back('{exp: exp, acc: cyc});
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = W'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", q.size(), 0);
    q.delete();
  endtask

  task automatic random_phase(input int cycles);
    logic [W-1:0] orig;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      orig     = W'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      in_word  = encode(orig);
      if (in_valid && in_ready) q.push_back('{exp: orig, acc: cyc});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
      hs_prev = 1'b0;
    end else begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      chk("in_ready_vs_busy", in_ready, !busy);
      chk("word_count", word_count, exp_count);
      if (hs_prev) chk("out_valid_drop", out_valid, 1'b0);
      if (out_valid && !prev_ov) begin
        chk("output_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) chk("latency", cyc, q[0].acc + N);
      end
      if (out_valid && q.size() != 0) chk("out_word", out_word, q[0].exp);
      hs_prev = out_valid && out_ready;
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        exp_count = exp_count + 16'd1;
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    mode      = 0;
    exp_count = 16'd0;
    prev_ov   = 1'b0;
    hs_prev   = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", out_word, 16'h0000);
    chk("rst_word_count", word_count, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("in_ready_after_rst", in_ready, 1'b1);

    // Directed words
    send(16'h153F, 16'h1BE4);
    drain();
    @(negedge clk);
    chk("count_after_first", word_count, 16'd1);
    send(16'hFFFF, 16'hE4E4);
    send(16'h0000, 16'h0000);
    drain();

    // Consumer stall with input noise
    mode = 2;
    send(16'h153F, 16'h1BE4);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    chk("stall_out_valid_rise", out_valid, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_word  = W'($urandom);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_out_word", out_word, 16'h1BE4);
    end
    in_valid = 1'b0;
    mode = 0;
    drain();
    @(negedge clk);
    chk("count_after_stall", word_count, 16'd4);

    // Reset mid-DECODE aborts the word in flight
    send(encode(16'hA5C3), 16'hA5C3);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    exp_count = 16'd0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_word_count", word_count, 16'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("abort_in_ready_release", in_ready, 1'b1);
    send(16'h153F, 16'h1BE4);
    drain();

    // Random stream with random backpressure
    mode = 1;
    random_phase(300);
    drain();

    // Counter wrap from a preloaded value
    @(posedge clk);
    #2 force dut.r_word_count = 16'hFFFE;
    exp_count = 16'hFFFE;
    @(posedge clk);
    #2 release dut.r_word_count;
    random_phase(200);
    drain();
    @(negedge clk);
    chk("wrap_happened", (exp_count < 16'hFFFE), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
